stage_if_prefetch: RTL

- Parametrised successor of the instruction fetch stage: a classic Wishbone master fetches sequential words into a FIFO prefetch buffer of configurable depth, decoupling bus latency from decode stalls.
- Redirects from branch/jump or exception select a new fetch PC. The redirect flushes the buffer and discards any in-flight response.
- Sits between the instruction Wishbone bus and the decode stage; presents registered {pc_o, instruction_o, valid_o}.

---
 rtl/stage_if_prefetch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage: a Wishbone classic master feeding a prefetch FIFO.
// Optional macro IF_BUS_ERR_EN adds fetch_err_o, a per-entry error bit and a fetch suspend.
module stage_if_prefetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] br_j_addr_i,
   input  logic [31:0] exception_addr_i,
   input  logic [1:0]  sel_addr_i,
   input  logic        stall_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o
`ifdef IF_BUS_ERR_EN
   ,
   output logic        fetch_err_o
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t            state_reg, state_next;
   logic [31:0]       fetch_pc_reg;
   logic [31:0]       bus_addr_reg;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [31:0]       pc_mem    [FIFO_DEPTH];
   logic [31:0]       instr_mem [FIFO_DEPTH];
   logic [31:0]       instr_reg, pc_reg;
   logic              valid_reg;

   logic              redirect, bus_done, push, pop;
   logic              fifo_full, fifo_empty, fetch_en;
   logic [31:0]       redirect_pc, push_instr;

   assign redirect    = (sel_addr_i == 2'b01) || (sel_addr_i == 2'b10);
   assign redirect_pc = ((sel_addr_i == 2'b01) ? br_j_addr_i : exception_addr_i) & ~32'h3;
   assign bus_done    = wbm_ack_i || wbm_err_i;
   assign fifo_full   = (count_reg == CNT_W'(FIFO_DEPTH));
   assign fifo_empty  = (count_reg == '0);
   // A redirect takes priority: a response arriving on the same edge is dropped.
   assign push        = (state_reg == REQ) && bus_done && !redirect;
   assign pop         = !redirect && !stall_i && !fifo_empty;
   assign push_instr  = wbm_err_i ? NOP_INSTR : wbm_dat_i;

`ifdef IF_BUS_ERR_EN
   logic suspend_reg;
   logic err_mem [FIFO_DEPTH];
   logic fetch_err_reg;

   assign fetch_en    = !suspend_reg;
   assign fetch_err_o = fetch_err_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i || redirect)
         suspend_reg <= 1'b0;
      else if (push && wbm_err_i)
         suspend_reg <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push)
         err_mem[wr_ptr_reg] <= wbm_err_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || redirect)
         fetch_err_reg <= 1'b0;
      else if (!stall_i)
         fetch_err_reg <= pop ? err_mem[rd_ptr_reg] : 1'b0;
   end
`else
   assign fetch_en = 1'b1;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (!fifo_full && !redirect && fetch_en) state_next = REQ;
         REQ:     if (bus_done) state_next = IDLE;
                  else if (redirect) state_next = DISCARD;
         DISCARD: if (bus_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wbm_cyc_o  = (state_reg != IDLE);
      wbm_stb_o  = (state_reg != IDLE);
      wbm_addr_o = {bus_addr_reg[31:2], 2'b00};
      wbm_dat_o  = 32'h0;
      wbm_sel_o  = 4'hF;
      wbm_we_o   = 1'b0;
   end

   // The bus address is latched at request start so it stays put through DISCARD.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         bus_addr_reg <= RESET_ADDR;
      else if (state_reg == IDLE && state_next == REQ)
         bus_addr_reg <= fetch_pc_reg;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         fetch_pc_reg <= RESET_ADDR;
      else if (redirect)
         fetch_pc_reg <= redirect_pc;
      else if (push)
         fetch_pc_reg <= fetch_pc_reg + 32'd4;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
         instr_mem[wr_ptr_reg] <= push_instr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || redirect) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)
            count_reg <= count_reg + CNT_W'(1);
         else if (pop && !push)
            count_reg <= count_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_reg <= NOP_INSTR;
         pc_reg    <= RESET_ADDR - 32'd4;
         valid_reg <= 1'b0;
      end else if (redirect) begin
         instr_reg <= NOP_INSTR;
         valid_reg <= 1'b0;
      end else if (!stall_i) begin
         if (pop) begin
            instr_reg <= instr_mem[rd_ptr_reg];
            pc_reg    <= pc_mem[rd_ptr_reg];
            valid_reg <= 1'b1;
         end else begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
         end
      end
   end

   assign instruction_o = instr_reg;
   assign pc_o          = pc_reg;
   assign valid_o       = valid_reg;

endmodule
